// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word fetches over a req/gnt bus
// with in-order responses, and buffers up to two fetched words for decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus4,
  output logic [6:0]  Op,
  output logic [2:0]  Funct3,
  output logic        Funct7b5,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CW    = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned OCCW  = 3;

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] word_q [DEPTH];
  logic [XLEN-1:0] word_d [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] pc_d   [DEPTH];

  logic            pop;
  logic            redirect;
  logic            accept;
  logic            push;
  logic            credit;
  logic [OCCW-1:0] occupancy;
  logic [XLEN-1:0] tgt_aligned;
  logic            unused_tgt_lsb;

  assign tgt_aligned    = {PCTarget[31:2], 2'b00};
  assign unused_tgt_lsb = ^PCTarget[1:0];

  // Handshake decode; a grant in the redirect cycle is still counted and later dropped.
  always_comb begin
    pop       = (count_q != '0) & instr_ready;
    redirect  = pop & PCSrc;
    occupancy = OCCW'(outstanding_q) + OCCW'(count_q) - OCCW'(pop);
    credit    = occupancy < OCCW'(2);
    imem_req  = rst_n & credit & (state_q == S_FETCH) & ~redirect;
    accept    = imem_gnt & (imem_req | redirect);
    push      = imem_rvalid & (discard_q == '0) & ~redirect;
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q - CW'(imem_rvalid) + CW'(accept);
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    word_d        = word_q;
    pc_d          = pc_q;

    if (redirect) begin
      fetch_pc_d = tgt_aligned;
      resp_pc_d  = tgt_aligned;
      discard_d  = outstanding_d;
      count_d    = '0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (imem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      if (push) begin
        word_d[wr_ptr_q] = imem_rdata;
        pc_d[wr_ptr_q]   = resp_pc_q;
        wr_ptr_d         = ~wr_ptr_q;
        resp_pc_d        = resp_pc_q + XLEN'(4);
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end

    case (state_q)
      S_FETCH: if (redirect && (discard_d != '0)) state_d = S_FLUSH;
      S_FLUSH: if (discard_d == '0) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= RESET_PC;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      word_q        <= word_d;
      pc_q          <= pc_d;
    end
  end

  // Head of the buffer drives decode; no bypass from the response bus.
  assign imem_addr     = fetch_pc_q;
  assign instr_valid   = (count_q != '0);
  assign instr         = word_q[rd_ptr_q];
  assign instr_pc      = pc_q[rd_ptr_q];
  assign instr_pcplus4 = instr_pc + XLEN'(4);
  assign Op            = instr[6:0];
  assign Funct3        = instr[14:12];
  assign Funct7b5      = instr[30];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed timing sequences, a redirect
// vector table, and randomized traffic checked against an instruction-stream model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;
  logic [6:0]  Op;
  logic [2:0]  Funct3;
  logic        Funct7b5;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = '0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_pcplus4(instr_pcplus4),
    .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5),
    .PCSrc(PCSrc), .PCTarget(PCTarget)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_pops = 0;

  // Memory model: in-order response queue with per-request due cycle.
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          gnt_drv = 1'b0;
  bit          gnt_random = 1'b0;

  // Instruction-stream model and per-cycle observations.
  logic [31:0] exp_pc = RST_PC;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_addr = '0;
  bit          o_req, o_valid, o_pop, o_redirect, o_accept;
  logic [31:0] o_addr;

  typedef struct {
    logic [31:0] trig;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic [31:0] exp_p4;
  } redir_vec_t;
  redir_vec_t tbl[4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, RST_PC);
    chk("rst_instr_pcplus4", instr_pcplus4, RST_PC + 32'd4);
    chk("rst_fields", 32'({Funct7b5, Funct3, Op}), 32'd0);
  endtask

  // Asserts reset asynchronously (mid-cycle), clears the memory side, releases after a posedge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0; PCSrc = 1'b0;
    mq_addr.delete(); mq_due.delete();
    last_due = 0; exp_pc = RST_PC; hold_pend = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // One bus cycle. src_mode: 0 no redirect, 1 redirect when popping src_pc, 2 redirect on any pop.
  task automatic cycle(input bit ready, input int src_mode, input logic [31:0] src_pc,
                       input logic [31:0] tgt);
    logic [31:0] w;
    int due;
    @(negedge clk);
    cyc++;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq_addr[0]);
      mq_addr.delete(0);
      mq_due.delete(0);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt    = gnt_random ? ($urandom_range(0, 9) < 7) : gnt_drv;
    instr_ready = ready;
    o_valid     = instr_valid;
    PCSrc       = o_valid & ready & ((src_mode == 2) || (src_mode == 1 && instr_pc == src_pc));
    PCTarget    = tgt;
    #1;
    o_req      = imem_req;
    o_addr     = imem_addr;
    o_pop      = instr_valid & instr_ready;
    o_redirect = o_pop & PCSrc;
    o_accept   = imem_gnt & (imem_req | o_redirect);

    if (o_req) chk("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
    if (hold_pend && !o_redirect) begin
      chk("hold_req", 32'(o_req), 32'd1);
      chk("hold_addr", o_addr, hold_addr);
    end
    hold_pend = o_req && !imem_gnt;
    hold_addr = o_addr;
    chk("push_while_full", 32'(dut.push & (dut.count_q == 2'd2)), 32'd0);

    if (o_pop) begin
      w = mem_word(exp_pc);
      chk("pop_pc", instr_pc, exp_pc);
      chk("pop_instr", instr, w);
      chk("pop_pcplus4", instr_pcplus4, exp_pc + 32'd4);
      chk("pop_fields", 32'({Funct7b5, Funct3, Op}), 32'({w[30], w[14:12], w[6:0]}));
      exp_pc = o_redirect ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
      n_pops++;
    end
    if (o_accept) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due < last_due) due = last_due;
      last_due = due;
      mq_addr.push_back(o_addr);
      mq_due.push_back(due);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int pops0;

    tbl[0] = '{trig: 32'h10, tgt: 32'h0000_0103, exp_pc: 32'h100,       exp_p4: 32'h104};
    tbl[1] = '{trig: 32'h08, tgt: 32'hFFFF_FFFE, exp_pc: 32'hFFFF_FFFC, exp_p4: 32'h0};
    tbl[2] = '{trig: 32'h04, tgt: 32'h0000_0041, exp_pc: 32'h40,        exp_p4: 32'h44};
    tbl[3] = '{trig: 32'h00, tgt: 32'h0000_0002, exp_pc: 32'h0,         exp_p4: 32'h4};

    // Reset release and streaming: back-to-back addresses, 2-cycle first latency.
    gnt_drv = 1'b1; lat_min = 1; lat_max = 1;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 0, '0, '0);
      chk("stream_req", 32'(o_req), 32'd1);
      chk("stream_addr", o_addr, RST_PC + 32'(4 * k));
      chk("stream_valid", 32'(o_valid), (k >= 2) ? 32'd1 : 32'd0);
    end

    // Decode stall: requests stop, nothing lost on resume.
    for (int s = 0; s < 6; s++) begin
      cycle(1'b0, 0, '0, '0);
      chk("stall_req", 32'(o_req), 32'd0);
    end
    cycle(1'b1, 0, '0, '0);
    chk("resume_pop", 32'(o_pop), 32'd1);
    for (int k = 0; k < 8; k++) cycle(1'b1, 0, '0, '0);

    // Grant withheld: request and address held at 0x8.
    do_reset();
    gnt_drv = 1'b1;
    cycle(1'b1, 0, '0, '0);
    cycle(1'b1, 0, '0, '0);
    gnt_drv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 0, '0, '0);
      chk("nogrant_req", 32'(o_req), 32'd1);
      chk("nogrant_addr", o_addr, 32'h8);
    end
    gnt_drv = 1'b1;
    cycle(1'b1, 0, '0, '0);
    chk("grant_accept", 32'(o_accept), 32'd1);
    chk("grant_addr", o_addr, 32'h8);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle(1'b1, 0, '0, '0);
      if (o_pop && instr_pc == 32'h8) found = 1'b1;
    end
    chk("grant_word8_delivered", 32'(found), 32'd1);

    // Redirect vectors: same-cycle grant+rvalid, penalty timing, target alignment and wrap.
    foreach (tbl[i]) begin
      do_reset();
      gnt_drv = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        cycle(1'b1, 1, tbl[i].trig, tbl[i].tgt);
        if (o_redirect) found = 1'b1;
      end
      chk("redir_taken", 32'(found), 32'd1);
      chk("redir_req_low", 32'(o_req), 32'd0);
      cycle(1'b1, 0, '0, '0);
      chk("redir_r1_req", 32'(o_req), 32'd0);
      chk("redir_r1_valid", 32'(o_valid), 32'd0);
      cycle(1'b1, 0, '0, '0);
      chk("redir_r2_req", 32'(o_req), 32'd1);
      chk("redir_r2_addr", o_addr, tbl[i].exp_pc);
      cycle(1'b1, 0, '0, '0);
      chk("redir_r3_valid", 32'(o_valid), 32'd0);
      cycle(1'b1, 0, '0, '0);
      chk("redir_r4_valid", 32'(o_valid), 32'd1);
      chk("redir_r4_pc", instr_pc, tbl[i].exp_pc);
      chk("redir_r4_pcplus4", instr_pcplus4, tbl[i].exp_p4);
      for (int k = 0; k < 4; k++) cycle(1'b1, 0, '0, '0);
    end

    // Redirect with no grant in the redirect cycle: nothing to discard, fetch resumes next cycle.
    do_reset();
    gnt_drv = 1'b1;
    for (int k = 0; k < 4; k++) cycle(1'b1, 0, '0, '0);
    gnt_drv = 1'b0;
    cycle(1'b1, 1, 32'h8, 32'h200);
    chk("nogrant_redir_taken", 32'(o_redirect), 32'd1);
    gnt_drv = 1'b1;
    cycle(1'b1, 0, '0, '0);
    chk("nogrant_redir_req", 32'(o_req), 32'd1);
    chk("nogrant_redir_addr", o_addr, 32'h200);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle(1'b1, 0, '0, '0);
      if (o_pop && instr_pc == 32'h200) found = 1'b1;
    end
    chk("nogrant_redir_delivered", 32'(found), 32'd1);

    // Reset mid-stream with a response outstanding, then restart from RESET_PC.
    do_reset();
    gnt_drv = 1'b1;
    for (int k = 0; k < 6; k++) cycle(1'b1, 0, '0, '0);
    chk("midrst_outstanding", 32'(o_accept), 32'd1);
    do_reset();
    cycle(1'b1, 0, '0, '0);
    chk("midrst_restart_req", 32'(o_req), 32'd1);
    chk("midrst_restart_addr", o_addr, RST_PC);
    for (int k = 0; k < 6; k++) cycle(1'b1, 0, '0, '0);
    chk("midrst_first_pcs", exp_pc, RST_PC + 32'd20);

    // Randomized traffic: random grants, latencies, stalls and redirects.
    do_reset();
    gnt_random = 1'b1; lat_min = 1; lat_max = 3;
    pops0 = n_pops;
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 9) < 3) ? $urandom : 32'($urandom_range(0, 1023));
      cycle($urandom_range(0, 3) != 0, ($urandom_range(0, 99) < 8) ? 2 : 0, '0, t);
    end
    chk("random_progress", 32'((n_pops - pops0) > 300), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
